// File: rtl/middle_finder_pkg.sv
// Shared constants for the sequential middle finder: one-hot states, sort steps, default width.
package middle_finder_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic [3:0] ST_INI  = 4'b0001;
  localparam logic [3:0] ST_LOAD = 4'b0010;
  localparam logic [3:0] ST_SORT = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  // Sort steps, selected by cnt while in SORT
  localparam logic [1:0] STEP_01  = 2'd0;
  localparam logic [1:0] STEP_12  = 2'd1;
  localparam logic [1:0] STEP_01B = 2'd2;

endpackage

// File: rtl/middle_finder_seq_cmp_swap.sv
// Combinational compare-and-swap: lo_out = min, hi_out = max; equal inputs pass straight through.
module cmp_swap #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  logic swap;

  assign swap   = lo_in > hi_in;
  assign lo_out = swap ? hi_in : lo_in;
  assign hi_out = swap ? lo_in : hi_in;

endmodule

// File: rtl/middle_finder_seq.sv
// Serial-load, three-step sort median finder with Done/Ack handshake.
// Define MIDDLE_FINDER_SEQ_MINMAX_EN to expose Min/Max ports.
module middle_finder_seq
  import middle_finder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             In_valid,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Ack,
  output logic             In_ready,
  output logic [WIDTH-1:0] Middle,
`ifdef MIDDLE_FINDER_SEQ_MINMAX_EN
  output logic [WIDTH-1:0] Min,
  output logic [WIDTH-1:0] Max,
`endif
  output logic             Done,
  output logic             q_Ini,
  output logic             q_Load,
  output logic             q_Sort,
  output logic             q_Done
);

  logic [3:0]       state;
  logic [1:0]       cnt;
  logic [WIDTH-1:0] x0, x1, x2;

  logic [WIDTH-1:0] cs_lo_in, cs_hi_in, cs_lo, cs_hi;

  // Single comparator shared by all three steps; step 1 works on (X1,X2)
  assign cs_lo_in = (cnt == STEP_12) ? x1 : x0;
  assign cs_hi_in = (cnt == STEP_12) ? x2 : x1;

  cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
    .lo_in  (cs_lo_in),
    .hi_in  (cs_hi_in),
    .lo_out (cs_lo),
    .hi_out (cs_hi)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_INI;
      cnt   <= 2'd0;
      x0    <= '0;
      x1    <= '0;
      x2    <= '0;
    end else begin
      case (state)
        ST_INI: begin
          if (Start) begin
            state <= ST_LOAD;
            cnt   <= 2'd0;
          end
        end
        ST_LOAD: begin
          if (In_valid) begin
            case (cnt)
              2'd0:    x0 <= Data_in;
              2'd1:    x1 <= Data_in;
              default: x2 <= Data_in;
            endcase
            if (cnt == 2'd2) begin
              state <= ST_SORT;
              cnt   <= 2'd0;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        ST_SORT: begin
          if (cnt == STEP_12) begin
            x1 <= cs_lo;
            x2 <= cs_hi;
          end else begin
            x0 <= cs_lo;
            x1 <= cs_hi;
          end
          if (cnt == STEP_01B) begin
            state <= ST_DONE;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (Ack) state <= ST_INI;
        end
        default: begin
          state <= ST_INI;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

  assign q_Ini    = state[0];
  assign q_Load   = state[1];
  assign q_Sort   = state[2];
  assign q_Done   = state[3];
  assign In_ready = q_Load;
  assign Done     = q_Done;
  assign Middle   = x1;
`ifdef MIDDLE_FINDER_SEQ_MINMAX_EN
  assign Min      = x0;
  assign Max      = x2;
`endif

endmodule

// File: tb/tb_middle_finder_seq.sv
// Randomised and exhaustive self-checking bench for middle_finder_seq against a rank-count model.
module tb_middle_finder_seq;

  localparam int WIDTH = 4;

  logic             Clk = 1'b0;
  logic             Reset, Start, In_valid, Ack;
  logic [WIDTH-1:0] Data_in;
  logic             In_ready, Done, q_Ini, q_Load, q_Sort, q_Done;
  logic [WIDTH-1:0] Middle;
`ifdef MIDDLE_FINDER_SEQ_MINMAX_EN
  logic [WIDTH-1:0] Min, Max;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  middle_finder_seq #(.WIDTH(WIDTH)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .In_valid (In_valid),
    .Data_in  (Data_in),
    .Ack      (Ack),
    .In_ready (In_ready),
    .Middle   (Middle),
`ifdef MIDDLE_FINDER_SEQ_MINMAX_EN
    .Min      (Min),
    .Max      (Max),
`endif
    .Done     (Done),
    .q_Ini    (q_Ini),
    .q_Load   (q_Load),
    .q_Sort   (q_Sort),
    .q_Done   (q_Done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rank-based reference: the median has at most one value strictly below and one strictly above
  function automatic int ref_med(input int a, input int b, input int c);
    int v[3];
    v = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      int lt = 0, gt = 0;
      for (int j = 0; j < 3; j++) begin
        if (v[j] < v[i]) lt++;
        if (v[j] > v[i]) gt++;
      end
      if (lt <= 1 && gt <= 1) return v[i];
    end
    return -1;
  endfunction

  function automatic int ref_min(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int ref_max(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One full transaction; inputs change and outputs are sampled on the falling edge.
  // gap_max: idle cycles before each operand; noise: wiggle Start/Ack where they must be ignored.
  task automatic run(input int a, input int b, input int c, input int gap_max, input bit noise);
    int ops[3];
    ops = '{a, b, c};
    if (noise) begin
      Ack = 1'b1;
      @(negedge Clk);
      Ack = 1'b0;
      chk("ack_in_ini", q_Ini, 1);
    end
    Start = 1'b1;
    @(negedge Clk);
    Start = noise;
    Ack   = noise;
    chk("load_entry", q_Load, 1);
    for (int k = 0; k < 3; k++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      for (int i = 0; i < g; i++) begin
        In_valid = 1'b0;
        Data_in  = WIDTH'($urandom);
        @(negedge Clk);
        chk("gap_ready", In_ready, 1);
      end
      In_valid = 1'b1;
      Data_in  = WIDTH'(ops[k]);
      @(negedge Clk);
    end
    In_valid = noise;
    Data_in  = WIDTH'($urandom);
    chk("sort_entry", q_Sort, 1);
    chk("sort_ready", In_ready, 0);
    @(negedge Clk);
    @(negedge Clk);
    chk("done_early", Done, 0);
    Ack = 1'b0;
    @(negedge Clk);
    chk("done_rise", Done, 1);
    chk("middle", Middle, ref_med(a, b, c));
`ifdef MIDDLE_FINDER_SEQ_MINMAX_EN
    chk("min", Min, ref_min(a, b, c));
    chk("max", Max, ref_max(a, b, c));
`endif
    if (noise) begin
      @(negedge Clk);
      Start = 1'b0;
      chk("start_in_done", q_Done, 1);
      chk("middle_hold", Middle, ref_med(a, b, c));
    end
    In_valid = 1'b0;
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    chk("ack_to_ini", q_Ini, 1);
    chk("done_fall", Done, 0);
  endtask

  task automatic load3(input int a, input int b, input int c);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      In_valid = 1'b1;
      Data_in  = WIDTH'((k == 0) ? a : (k == 1) ? b : c);
      @(negedge Clk);
    end
    In_valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; In_valid = 1'b0; Ack = 1'b0; Data_in = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_ini", q_Ini, 1);
    chk("rst_state", {q_Load, q_Sort, q_Done}, 0);
    chk("rst_ready", In_ready, 0);
    chk("rst_done", Done, 0);
    chk("rst_middle", Middle, 0);

    run(9, 3, 7, 0, 1'b0);
    run(0, 1, 1, 0, 1'b0);
    run(0, 1, 1, 2, 1'b0);
    run(15, 15, 0, 0, 1'b0);
    run(2, 2, 2, 1, 1'b0);

    // Reset during the second SORT cycle
    load3(5, 10, 2);
    @(negedge Clk);
    chk("mid_sort", q_Sort, 1);
    Reset = 1'b1;
    Start = 1'b1;
    Ack   = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0; Ack = 1'b0;
    chk("rst_sort_ini", q_Ini, 1);
    chk("rst_sort_done", Done, 0);
    chk("rst_sort_mid", Middle, 0);
`ifdef MIDDLE_FINDER_SEQ_MINMAX_EN
    chk("rst_sort_min", Min, 0);
    chk("rst_sort_max", Max, 0);
`endif
    run(2, 5, 10, 0, 1'b0);

    run(4, 8, 6, 1, 1'b1);

    for (int i = 0; i < 100; i++)
      run($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0),
          $urandom_range(2, 0), 1'($urandom));

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++)
          run(a, b, c, ($urandom_range(3, 0) == 0) ? 1 : 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
